uart_fifo_ctrl: RTL

Buffered sequencer between the J1a I/O bus and the `buart` core. It holds a transmit FIFO and a receive FIFO, and issues the one-cycle `wr`/`rd` strobes to `buart` through its `busy`/`valid` handshake. The CPU therefore never polls the UART per byte. It instantiates next to `buart`, and the two share the same clock.

---
 rtl/uart_fifo_ctrl.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: buffered sequencer between the J1a I/O bus and the buart core.
// It holds a 2^DEPTH_LOG2-entry TX FIFO and RX FIFO and drives the one-cycle
// wr/rd strobes of buart through its busy/valid handshake.
// Optional feature: define UART_RTS_EN to add the registered active-low rts_n
// output, which deasserts (goes high) once the RX level reaches RTS_THRESH.

// Circular byte FIFO with a registered show-ahead head and a separate level counter.
module uart_fifo_ctrl_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE_LEVEL  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr_after;
  logic                  push_ok;
  logic                  pop_ok;

  // Full/empty come from the level at the start of the cycle, so a push
  // while full is dropped even if a pop frees a slot in the same cycle.
  assign full         = (level == FULL_LEVEL);
  assign empty        = (level == '0);
  assign push_ok      = push && !full;
  assign pop_ok       = pop && !empty;
  assign rd_ptr_after = rd_ptr + 1'b1;

  // Storage array; contents are only meaningful below the level, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo depth; the level moves only when exactly one side acts.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr_after;
      end
      if (push_ok && !pop_ok) begin
        level <= level + 1'b1;
      end else if (!push_ok && pop_ok) begin
        level <= level - 1'b1;
      end
    end
  end

  // Head register tracks the next oldest entry and holds when the FIFO drains.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      head <= 8'h00;
    end else if (push_ok && (empty || (pop_ok && level == ONE_LEVEL))) begin
      head <= push_data;
    end else if (pop_ok && level > ONE_LEVEL) begin
      head <= mem[rd_ptr_after];
    end
  end

endmodule

// Top level: TX FIFO + TX sequencer, RX FIFO + RX sequencer, optional RTS.
module uart_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4,
  parameter int RTS_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  resetq,
  input  logic                  tx_push,
  input  logic [7:0]            tx_byte,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_level,
  input  logic                  rx_pop,
  output logic [7:0]            rx_byte,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_level,
  output logic                  uart_wr,
  output logic [7:0]            uart_tx_data,
  input  logic                  uart_busy,
  output logic                  uart_rd,
  input  logic                  uart_valid,
  input  logic [7:0]            uart_rx_data
`ifdef UART_RTS_EN
  ,
  output logic                  rts_n
`endif
);

  typedef enum logic [1:0] {
    T_IDLE,
    T_ISSUE,
    T_DRAIN
  } tx_state_t;

  typedef enum logic {
    R_IDLE,
    R_ACK
  } rx_state_t;

  tx_state_t  tx_state;
  tx_state_t  tx_state_next;
  logic       drain_seen_busy;
  logic       drain_seen_busy_next;
  logic       uart_wr_next;
  logic [7:0] uart_tx_data_next;
  logic       tx_pop;
  logic [7:0] tx_head;
  logic       tx_empty;

  rx_state_t  rx_state;
  rx_state_t  rx_state_next;
  logic       rx_push;
  logic       uart_rd_next;
  logic       rx_full;

  uart_fifo_ctrl_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_tx_fifo (
    .clk       (clk),
    .resetq    (resetq),
    .push      (tx_push),
    .push_data (tx_byte),
    .pop       (tx_pop),
    .head      (tx_head),
    .level     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  uart_fifo_ctrl_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_rx_fifo (
    .clk       (clk),
    .resetq    (resetq),
    .push      (rx_push),
    .push_data (uart_rx_data),
    .pop       (rx_pop),
    .head      (rx_byte),
    .level     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // TX sequencer state and its registered buart-facing outputs.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state        <= T_IDLE;
      drain_seen_busy <= 1'b0;
      uart_wr         <= 1'b0;
      uart_tx_data    <= 8'h00;
    end else begin
      tx_state        <= tx_state_next;
      drain_seen_busy <= drain_seen_busy_next;
      uart_wr         <= uart_wr_next;
      uart_tx_data    <= uart_tx_data_next;
    end
  end

  // TX next state: launch one byte, then wait for a full busy high/low cycle
  // so the busy-still-low first drain cycle is never mistaken for completion.
  always_comb begin
    tx_state_next        = tx_state;
    drain_seen_busy_next = drain_seen_busy;
    uart_wr_next         = 1'b0;
    uart_tx_data_next    = uart_tx_data;
    tx_pop               = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (!tx_empty && !uart_busy) begin
          tx_state_next     = T_ISSUE;
          uart_wr_next      = 1'b1;
          uart_tx_data_next = tx_head;
          tx_pop            = 1'b1;
        end
      end
      T_ISSUE: begin
        tx_state_next        = T_DRAIN;
        drain_seen_busy_next = 1'b0;
      end
      T_DRAIN: begin
        if (!drain_seen_busy) begin
          if (uart_busy) begin
            drain_seen_busy_next = 1'b1;
          end
        end else if (!uart_busy) begin
          tx_state_next = T_IDLE;
        end
      end
      default: begin
        tx_state_next = T_IDLE;
      end
    endcase
  end

  // RX sequencer state and its registered rd strobe.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_state <= R_IDLE;
      uart_rd  <= 1'b0;
    end else begin
      rx_state <= rx_state_next;
      uart_rd  <= uart_rd_next;
    end
  end

  // RX next state: capture once per valid pulse; a full FIFO leaves the byte
  // waiting in buart until a slot frees.
  always_comb begin
    rx_state_next = rx_state;
    rx_push       = 1'b0;
    uart_rd_next  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (uart_valid && !rx_full) begin
          rx_push       = 1'b1;
          uart_rd_next  = 1'b1;
          rx_state_next = R_ACK;
        end
      end
      R_ACK: begin
        if (!uart_valid) begin
          rx_state_next = R_IDLE;
        end
      end
      default: begin
        rx_state_next = R_IDLE;
      end
    endcase
  end

`ifdef UART_RTS_EN
  localparam logic [DEPTH_LOG2:0] RTS_LEVEL = RTS_THRESH[DEPTH_LOG2:0];

  // RTS follows the registered RX level one cycle later.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rts_n <= 1'b0;
    end else begin
      rts_n <= (rx_level >= RTS_LEVEL);
    end
  end
`endif

endmodule
